snake_input_ctrl: RTL and testbench

//  Board-side producer of the Snake_Game control inputs. Synchronises and debounces four raw

---
 rtl/snake_input_ctrl.sv | 147 ++++++++++++++
 tb/tb_snake_input_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: board-side input conditioning for the Snake game.
// Each of the four active-low direction buttons and the active-low pause button
// passes through its own synchroniser and its own debounce FSM. The debounced
// levels feed three registered outputs:
//   - o_Push      : priority-encoded, active-low direction (lowest index wins)
//   - o_Press_Evt : one-cycle pulse whenever o_Push takes a new pressed value
//   - o_Pause     : pause state, toggled by each press of the pause button
module snake_input_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CLK     = 1_000,
    parameter int CNT_W       = 20
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Btn,
    input  logic       i_Pause_Btn,
    input  logic       i_Pause_Clr,
    output logic [3:0] o_Push,
    output logic       o_Pause,
    output logic       o_Press_Evt
);

    localparam int N_IN = 5;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } deb_state_t;

    // Bit 4 is the pause button; bits 3:0 are the direction buttons.
    logic [N_IN-1:0] raw_in;
    logic [N_IN-1:0] deb_vec;

    assign raw_in = {i_Pause_Btn, i_Btn};

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   sync_lvl;
            deb_state_t             state_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic                   deb_reg;

            // Synchroniser chain; resets to the released level (1).
            always_ff @(posedge i_Clk or negedge i_Rst) begin
                if (!i_Rst) begin
                    sync_reg <= '1;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
                end
            end

            assign sync_lvl = sync_reg[SYNC_STAGES-1];

            // Debounce FSM: accept a new level only after DEB_CLK consecutive
            // differing samples; any return to the old level restarts the count.
            always_ff @(posedge i_Clk or negedge i_Rst) begin
                if (!i_Rst) begin
                    state_reg <= ST_STABLE;
                    cnt_reg   <= '0;
                    deb_reg   <= 1'b1;
                end else begin
                    case (state_reg)
                        ST_STABLE: begin
                            if (sync_lvl != deb_reg) begin
                                state_reg <= ST_CHANGING;
                                cnt_reg   <= CNT_W'(1);
                            end else begin
                                cnt_reg   <= '0;
                            end
                        end
                        ST_CHANGING: begin
                            if (sync_lvl == deb_reg) begin
                                // Glitch: level came back before it was accepted.
                                state_reg <= ST_STABLE;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == CNT_W'(DEB_CLK - 1)) begin
                                deb_reg   <= sync_lvl;
                                state_reg <= ST_STABLE;
                                cnt_reg   <= '0;
                            end else begin
                                cnt_reg   <= cnt_reg + CNT_W'(1);
                            end
                        end
                        default: begin
                            state_reg <= ST_STABLE;
                            cnt_reg   <= '0;
                        end
                    endcase
                end
            end

            assign deb_vec[gi] = deb_reg;
        end
    endgenerate

    logic [3:0] push_next;
    logic       evt_next;
    logic [3:0] push_reg;
    logic       evt_reg;
    logic       pause_reg;
    logic       pause_prev_reg;

    // Priority encode the debounced directions: the lowest pressed index wins,
    // so scan from the top and let lower indices overwrite.
    always_comb begin
        push_next = 4'b1111;
        for (int k = 3; k >= 0; k--) begin
            if (!deb_vec[k]) begin
                push_next    = 4'b1111;
                push_next[k] = 1'b0;
            end
        end
        evt_next = (push_next != push_reg) && (push_next != 4'b1111);
    end

    // Registered direction output and its press event, aligned to the same cycle.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            push_reg <= 4'b1111;
            evt_reg  <= 1'b0;
        end else begin
            push_reg <= push_next;
            evt_reg  <= evt_next;
        end
    end

    // Pause state: toggle on each debounced press (1->0), clear wins over toggle.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            pause_prev_reg <= 1'b1;
            pause_reg      <= 1'b0;
        end else begin
            pause_prev_reg <= deb_vec[4];
            if (i_Pause_Clr) begin
                pause_reg <= 1'b0;
            end else if (pause_prev_reg && !deb_vec[4]) begin
                pause_reg <= ~pause_reg;
            end
        end
    end

    assign o_Push      = push_reg;
    assign o_Press_Evt = evt_reg;
    assign o_Pause     = pause_reg;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl with DEB_CLK=4, SYNC_STAGES=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// so "step(k)" lands half a period after the k-th rising edge since the change.
module tb_snake_input_ctrl;

    logic       i_Clk;
    logic       i_Rst;
    logic [3:0] i_Btn;
    logic       i_Pause_Btn;
    logic       i_Pause_Clr;
    logic [3:0] o_Push;
    logic       o_Pause;
    logic       o_Press_Evt;

    int checks   = 0;
    int failures = 0;

    snake_input_ctrl #(
        .SYNC_STAGES (2),
        .DEB_CLK     (4),
        .CNT_W       (20)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_Btn       (i_Btn),
        .i_Pause_Btn (i_Pause_Btn),
        .i_Pause_Clr (i_Pause_Clr),
        .o_Push      (o_Push),
        .o_Pause     (o_Pause),
        .o_Press_Evt (o_Press_Evt)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic step(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        $display("check %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_outs(input string tag, input logic [3:0] push,
                              input logic evt, input logic pause);
        check({tag, ".push"},  o_Push,                push);
        check({tag, ".evt"},   {3'b000, o_Press_Evt}, {3'b000, evt});
        check({tag, ".pause"}, {3'b000, o_Pause},     {3'b000, pause});
    endtask

    initial begin
        i_Rst       = 1'b1;
        i_Btn       = 4'b1111;
        i_Pause_Btn = 1'b1;
        i_Pause_Clr = 1'b0;

        // 1: asynchronous reset with random buttons, before any clock edge.
        #2;
        i_Btn       = 4'($urandom_range(0, 15));
        i_Pause_Btn = 1'($urandom_range(0, 1));
        i_Rst       = 1'b0;
        #1;
        check_outs("reset_async", 4'b1111, 1'b0, 1'b0);
        step(3);
        check_outs("reset_held", 4'b1111, 1'b0, 1'b0);
        i_Btn       = 4'b1111;
        i_Pause_Btn = 1'b1;
        step(1);
        i_Rst = 1'b1;
        step(4);
        check_outs("post_reset", 4'b1111, 1'b0, 1'b0);

        // 2: clean press of btn1, then release.
        i_Btn = 4'b1101;
        step(6);
        check_outs("press_e6", 4'b1111, 1'b0, 1'b0);
        step(1);
        check_outs("press_e7", 4'b1101, 1'b1, 1'b0);
        step(1);
        check_outs("press_e8", 4'b1101, 1'b0, 1'b0);
        step(5);
        i_Btn = 4'b1111;
        step(6);
        check_outs("release_e6", 4'b1101, 1'b0, 1'b0);
        step(1);
        check_outs("release_e7", 4'b1111, 1'b0, 1'b0);
        step(1);
        check_outs("release_e8", 4'b1111, 1'b0, 1'b0);

        // 3: btn0 bouncing every 2 cycles must never be accepted.
        for (int i = 0; i < 5; i++) begin
            i_Btn[0] = 1'b0;
            step(2);
            i_Btn[0] = 1'b1;
            step(2);
        end
        for (int i = 0; i < 10; i++) begin
            step(1);
            check($sformatf("bounce_push_%0d", i), o_Push, 4'b1111);
            check($sformatf("bounce_evt_%0d", i), {3'b000, o_Press_Evt}, 4'b0000);
        end

        // 4: priority - btn2, then btn0 while btn2 held, then release btn0.
        i_Btn = 4'b1011;
        step(7);
        check_outs("pri_b2", 4'b1011, 1'b1, 1'b0);
        step(1);
        check_outs("pri_b2_hold", 4'b1011, 1'b0, 1'b0);
        step(3);
        i_Btn = 4'b1010;
        step(6);
        check_outs("pri_b0_e6", 4'b1011, 1'b0, 1'b0);
        step(1);
        check_outs("pri_b0", 4'b1110, 1'b1, 1'b0);
        step(1);
        check_outs("pri_b0_hold", 4'b1110, 1'b0, 1'b0);
        step(3);
        i_Btn = 4'b1011;
        step(7);
        check_outs("pri_rel_b0", 4'b1011, 1'b1, 1'b0);
        step(1);
        check_outs("pri_rel_b0_hold", 4'b1011, 1'b0, 1'b0);
        i_Btn = 4'b1111;
        step(7);
        check_outs("pri_rel_all", 4'b1111, 1'b0, 1'b0);
        step(1);
        check_outs("pri_rel_all_e8", 4'b1111, 1'b0, 1'b0);

        // 5: pause toggling, holding, and synchronous clear.
        i_Pause_Btn = 1'b0;
        step(6);
        check("pause1_e6", {3'b000, o_Pause}, 4'b0000);
        step(1);
        check("pause1_e7", {3'b000, o_Pause}, 4'b0001);
        step(43);
        check("pause1_hold50", {3'b000, o_Pause}, 4'b0001);
        i_Pause_Btn = 1'b1;
        step(10);
        check("pause1_release", {3'b000, o_Pause}, 4'b0001);
        i_Pause_Btn = 1'b0;
        step(7);
        check("pause2_toggle", {3'b000, o_Pause}, 4'b0000);
        step(5);
        i_Pause_Btn = 1'b1;
        step(10);
        check("pause2_release", {3'b000, o_Pause}, 4'b0000);
        // Clear asserted exactly on the edge where the toggle would happen.
        i_Pause_Btn = 1'b0;
        step(6);
        i_Pause_Clr = 1'b1;
        step(1);
        check("pause3_clr_wins", {3'b000, o_Pause}, 4'b0000);
        i_Pause_Clr = 1'b0;
        step(5);
        check("pause3_hold", {3'b000, o_Pause}, 4'b0000);
        i_Pause_Btn = 1'b1;
        step(10);
        i_Pause_Btn = 1'b0;
        step(7);
        check("pause4_toggle", {3'b000, o_Pause}, 4'b0001);
        i_Pause_Clr = 1'b1;
        step(1);
        check("pause4_clr", {3'b000, o_Pause}, 4'b0000);
        i_Pause_Clr = 1'b0;
        i_Pause_Btn = 1'b1;
        step(10);
        i_Pause_Btn = 1'b0;
        step(7);
        check("pause5_toggle", {3'b000, o_Pause}, 4'b0001);
        i_Pause_Btn = 1'b1;
        step(10);
        check_outs("pause5_idle", 4'b1111, 1'b0, 1'b1);

        // 6: reset in the middle of a debounce; the press must restart from scratch.
        i_Btn = 4'b1101;
        step(4);
        i_Rst = 1'b0;
        #1;
        check_outs("midreset_async", 4'b1111, 1'b0, 1'b0);
        step(1);
        i_Rst = 1'b1;
        step(6);
        check_outs("midreset_e6", 4'b1111, 1'b0, 1'b0);
        step(1);
        check_outs("midreset_e7", 4'b1101, 1'b1, 1'b0);
        step(1);
        check_outs("midreset_e8", 4'b1101, 1'b0, 1'b0);

        i_Btn = 4'b1111;
        step(10);
        check_outs("final_idle", 4'b1111, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
